// File: rtl/riscv_lsu_pkg.sv
// Shared size codes and FSM state type for the load-store unit.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    IDLE,
    BUSY
  } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_if.sv
// Word-addressed, byte-enabled data memory bus with a ready handshake.
interface riscv_lsu_if;

  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;

  modport master (output req, we, be, addr, wd, input rd, ready);
  modport slave  (input req, we, be, addr, wd, output rd, ready);

endinterface

// File: rtl/riscv_lsu_load_extend.sv
// Load realignment: picks the addressed byte/halfword from a bus word and extends it.
module lsu_load_extend
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] rd_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  output logic [31:0] rd_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_i[7:0];
    unique case (off_i)
      2'd0: byte_sel = rd_i[7:0];
      2'd1: byte_sel = rd_i[15:8];
      2'd2: byte_sel = rd_i[23:16];
      2'd3: byte_sel = rd_i[31:24];
    endcase
    half_sel = off_i[1] ? rd_i[31:16] : rd_i[15:0];
  end

  always_comb begin
    rd_o = rd_i;
    case (size_i)
      LDST_B:  rd_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: rd_o = {24'h0, byte_sel};
      LDST_H:  rd_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: rd_o = {16'h0, half_sel};
      default: rd_o = rd_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: core data port to byte-enabled memory bus, stalling the core until ready.
// Define RISCV_LSU_MISALIGN_TRAP_EN to flag misaligned H/HU/W accesses instead of forcing alignment.
module riscv_lsu
  import riscv_lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misaligned_o,
  riscv_lsu_if.master mem
);

  lsu_state_t  state_q, state_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        req;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  assign misaligned_o = core_req_i &
                        ((((core_size_i == LDST_H) | (core_size_i == LDST_HU)) & core_addr_i[0]) |
                         ((core_size_i == LDST_W) & (core_addr_i[1:0] != 2'b00)));
`else
  assign misaligned_o = 1'b0;
`endif

  assign req          = core_req_i & ~misaligned_o;
  assign core_stall_o = req & ~((state_q == BUSY) & mem.ready);

  assign mem.req  = req;
  assign mem.we   = core_we_i & req;
  assign mem.addr = {core_addr_i[31:2], 2'b00};

  // Halfword lanes come from addr[1] alone, so an odd H address falls back to its aligned halfword.
  always_comb begin
    mem.be = 4'b1111;
    mem.wd = core_wd_i;
    case (core_size_i)
      LDST_B: begin
        mem.be = 4'b0001 << core_addr_i[1:0];
        mem.wd = {4{core_wd_i[7:0]}};
      end
      LDST_H: begin
        mem.be = core_addr_i[1] ? 4'b1100 : 4'b0011;
        mem.wd = {2{core_wd_i[15:0]}};
      end
      default: begin
        mem.be = 4'b1111;
        mem.wd = core_wd_i;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    off_d   = off_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          size_d  = core_size_i;
          off_d   = core_addr_i[1:0];
        end
      end
      BUSY: begin
        if (!core_req_i || mem.ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      size_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      off_q   <= off_d;
    end
  end

  lsu_load_extend u_load_extend (
    .rd_i   (mem.rd),
    .size_i (size_q),
    .off_i  (off_q),
    .rd_o   (core_rd_o)
  );

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized self-checking bench for riscv_lsu against a byte-lane reference model.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  riscv_lsu_if mem_bus ();

  riscv_lsu dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_size_i  (core_size),
    .core_addr_i  (core_addr),
    .core_wd_i    (core_wd),
    .core_rd_o    (core_rd),
    .core_stall_o (core_stall),
    .misaligned_o (misaligned),
    .mem          (mem_bus)
  );

  always #5 clk = ~clk;

  // Reference model: think in bytes and lanes rather than bit slices.
  function automatic int unsigned acc_bytes(input logic [2:0] size);
    if (size == 3'd0 || size == 3'd4) return 1;
    if (size == 3'd1 || size == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int unsigned first_lane(input int unsigned n, input logic [31:0] addr);
    if (n == 4) return 0;
    return (addr % 4) / n * n;
  endfunction

  function automatic logic exp_mis(input logic [2:0] size, input logic [31:0] addr);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    if (size == 3'd1 || size == 3'd5 || size == 3'd2) return (addr % acc_bytes(size)) != 0;
    return 1'b0;
`else
    return (size == 3'd7) && (addr == 32'h0) && 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] size, input logic [31:0] addr);
    int unsigned n;
    int unsigned b;
    logic [3:0] be;
    n  = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
    b  = first_lane(n, addr);
    be = '0;
    for (int unsigned i = 0; i < n; i++) be[b + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] size, input logic [31:0] wd);
    int unsigned n;
    logic [31:0] v;
    n = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
    v = '0;
    for (int unsigned lane = 0; lane < 4; lane++)
      v |= ((wd >> (8 * (lane % n))) & 32'hFF) << (8 * lane);
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] size, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int unsigned n;
    int unsigned b;
    logic [31:0] v;
    n = acc_bytes(size);
    b = first_lane(n, addr);
    v = '0;
    for (int unsigned i = 0; i < n; i++)
      v |= ((rd >> (8 * (b + i))) & 32'hFF) << (8 * i);
    if ((size == 3'd0 || size == 3'd1) && v[8 * n - 1])
      v |= ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  // One core access with `waits` ready-low cycles after the request cycle; called right after a posedge.
  task automatic do_access(input string name, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int unsigned waits);
    int unsigned stalls;
    stalls        = 0;
    core_req      = 1'b1;
    core_we       = we;
    core_size     = size;
    core_addr     = addr;
    core_wd       = wd;
    mem_bus.ready = 1'b0;
    mem_bus.rd    = $urandom;
    if (exp_mis(size, addr)) begin
      #4;
      checks++;
      if (misaligned !== 1'b1 || mem_bus.req !== 1'b0 || core_stall !== 1'b0) begin
        errors++;
        $display("FAIL %s_mis: mis=%b req=%b stall=%b required mis=1 req=0 stall=0",
                 name, misaligned, mem_bus.req, core_stall);
      end
      @(posedge clk); #1;
      core_req = 1'b0;
      return;
    end
    for (int unsigned c = 0; c <= waits + 1; c++) begin
      if (c == waits + 1) begin
        mem_bus.ready = 1'b1;
        mem_bus.rd    = rd;
      end
      #4;
      checks++;
      if (mem_bus.req !== 1'b1 || mem_bus.we !== we || misaligned !== 1'b0) begin
        errors++;
        $display("FAIL %s_req c%0d: req=%b we=%b mis=%b required 1 %b 0",
                 name, c, mem_bus.req, mem_bus.we, misaligned, we);
      end
      checks++;
      if (mem_bus.be !== exp_be(size, addr) || mem_bus.addr !== (addr & ~32'h3)) begin
        errors++;
        $display("FAIL %s_bus c%0d: be=%b addr=%h required be=%b addr=%h",
                 name, c, mem_bus.be, mem_bus.addr, exp_be(size, addr), addr & ~32'h3);
      end
      if (we) begin
        checks++;
        if (mem_bus.wd !== exp_wd(size, wd)) begin
          errors++;
          $display("FAIL %s_wd c%0d: got %h required %h", name, c, mem_bus.wd, exp_wd(size, wd));
        end
      end
      checks++;
      if (core_stall !== (c != waits + 1)) begin
        errors++;
        $display("FAIL %s_stall c%0d: got %b required %b", name, c, core_stall, c != waits + 1);
      end
      if (core_stall === 1'b1) stalls++;
      if (c == waits + 1 && !we) begin
        checks++;
        if (core_rd !== exp_rd(size, addr, rd)) begin
          errors++;
          $display("FAIL %s_rd: got %h required %h", name, core_rd, exp_rd(size, addr, rd));
        end
      end
      @(posedge clk); #1;
    end
    core_req      = 1'b0;
    mem_bus.ready = 1'b0;
    checks++;
    if (stalls != waits + 1) begin
      errors++;
      $display("FAIL %s_stall_count: got %0d required %0d", name, stalls, waits + 1);
    end
  endtask

  task automatic test_reset();
    rst_i         = 1'b1;
    core_req      = 1'b0;
    core_we       = 1'b0;
    core_size     = 3'd2;
    core_addr     = '0;
    core_wd       = '0;
    mem_bus.ready = 1'b0;
    mem_bus.rd    = 32'h1234_56F0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    #4;
    checks++;
    if (core_stall !== 1'b0 || mem_bus.req !== 1'b0 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b req=%b mis=%b required 0 0 0",
               core_stall, mem_bus.req, misaligned);
    end
    // Reset leaves a signed-byte load at offset 0 selected.
    checks++;
    if (core_rd !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL reset_rd: got %h required %h", core_rd, 32'hFFFF_FFF0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    do_access("sw", 1'b1, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0);
    do_access("sb", 1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0);
    do_access("sh", 1'b1, 3'd1, 32'h0000_0202, 32'h1234_5678, 32'h0, 1);
    // Spot-check the worked values independently of the model.
    core_req = 1'b1; core_we = 1'b1; core_size = 3'd0;
    core_addr = 32'h0000_0103; core_wd = 32'h0000_00A5;
    #4;
    checks++;
    if (mem_bus.be !== 4'b1000 || mem_bus.wd !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL sb_literal: be=%b wd=%h required 1000 a5a5a5a5", mem_bus.be, mem_bus.wd);
    end
    mem_bus.ready = 1'b0;
    @(posedge clk); #1;
    mem_bus.ready = 1'b1;
    @(posedge clk); #1;
    core_req = 1'b0; mem_bus.ready = 1'b0;
  endtask

  task automatic test_load();
    do_access("lb",  1'b0, 3'd0, 32'h0000_0102, 32'h0, 32'h0080_0000, 0);
    do_access("lbu", 1'b0, 3'd4, 32'h0000_0102, 32'h0, 32'h0080_0000, 0);
    checks++;
    if (exp_rd(3'd0, 32'h102, 32'h0080_0000) !== 32'hFFFF_FF80 ||
        core_rd !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_literal: got %h required %h", core_rd, 32'h0000_0080);
    end
    do_access("lhu", 1'b0, 3'd5, 32'h0000_0100, 32'h0, 32'h1234_F00D, 1);
  endtask

  task automatic test_wait_states();
    do_access("lh_wait", 1'b0, 3'd1, 32'h0000_0102, 32'h0, 32'h8001_0000, 5);
  endtask

  task automatic test_reset_mid_busy();
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2;
    core_addr = 32'h0000_0200; core_wd = '0;
    mem_bus.ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    mem_bus.ready = 1'b1;
    mem_bus.rd    = 32'hCAFE_0001;
    #4;
    checks++;
    if (core_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_first: stall=%b required 1", core_stall);
    end
    @(posedge clk); #1;
    #4;
    checks++;
    if (core_stall !== 1'b0 || core_rd !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL rst_busy_done: stall=%b rd=%h required 0 cafe0001", core_stall, core_rd);
    end
    @(posedge clk); #1;
    core_req = 1'b0; mem_bus.ready = 1'b0;
  endtask

  task automatic test_misalign();
    do_access("lw_mis", 1'b0, 3'd2, 32'h0000_0101, 32'h0, 32'h0BAD_F00D, 0);
    do_access("lh_mis", 1'b0, 3'd1, 32'h0000_0103, 32'h0, 32'hF00D_1234, 0);
    // A normal access right after must still start from IDLE.
    do_access("lw_after", 1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'h1111_2222, 0);
  endtask

  task automatic test_back_to_back();
    do_access("b2b0", 1'b1, 3'd2, 32'h0000_0010, 32'hA1A2_A3A4, 32'h0, 0);
    do_access("b2b1", 1'b0, 3'd0, 32'h0000_0013, 32'h0, 32'h80FF_FFFF, 0);
    do_access("b2b2", 1'b0, 3'd5, 32'h0000_0016, 32'h0, 32'h9ABC_0000, 0);
  endtask

  task automatic test_random();
    logic [2:0] sizes [5];
    logic [2:0] sz;
    logic       we;
    sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 40; i++) begin
      sz = sizes[$urandom_range(0, 4)];
      we = (sz <= 3'd2) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_access("rnd", we, sz, $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_wait_states();
    test_reset_mid_busy();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
